// File: rtl/game_pkg.sv
// Shared types and constants for the breakout game-flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SERVE       = 3'd1,
        PLAY        = 3'd2,
        PAUSE_LOST  = 3'd3,
        PAUSE_CLEAR = 3'd4,
        GAME_OVER   = 3'd5,
        WIN         = 3'd6
    } state_t;

    localparam int unsigned LIVES_W = 3;
    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned CNT_W   = 7;

    localparam int unsigned SERVE_FRAMES_DEF = 60;
    localparam int unsigned PAUSE_FRAMES_DEF = 90;

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// Saturating frame_tick counter with clear; done once the count reaches a runtime limit.
module frame_timer
    import game_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // clear wins over tick so a frame arriving on a state change is not counted in the new state
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count >= limit);

endmodule

// File: rtl/game_ctrl.sv
// Breakout game-flow FSM: serve/play/pause sequencing, lives, level and end-of-game flags.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned N_BLOCKS     = 5,
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned MAX_LEVEL    = 4,
    parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int unsigned PAUSE_FRAMES = PAUSE_FRAMES_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                frame_tick,
    input  logic                ball_lost,
    input  logic                block_bottom,
    input  logic [N_BLOCKS-1:0] blocks_alive,
    output logic                run,
    output logic                serve,
    output logic                level_restart,
    output logic [LIVES_W-1:0]  lives,
    output logic [LEVEL_W-1:0]  level,
    output logic                game_over,
    output logic                game_won,
    output logic [2:0]          state_dbg
);

    localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

    state_t             state, state_nxt;
    logic [LIVES_W-1:0] lives_nxt;
    logic [LEVEL_W-1:0] level_nxt;
    logic               serve_nxt, restart_nxt;
    logic               ball_lost_q, lost_evt;
    logic               restart_d1, restart_d2, clear_guard;
    logic               timer_done, timer_clear;
    logic [CNT_W-1:0]   timer_limit;

    assign lost_evt    = ball_lost & ~ball_lost_q;
    // bloco exist flags lag the respawn by a cycle, so an empty vector right after it is stale
    assign clear_guard = level_restart | restart_d1 | restart_d2;
    assign timer_clear = (state_nxt != state);
    assign timer_limit = (state == SERVE) ? CNT_W'(SERVE_FRAMES) : CNT_W'(PAUSE_FRAMES);

    frame_timer u_timer (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear),
        .tick  (frame_tick),
        .limit (timer_limit),
        .done  (timer_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            lives         <= LIVES_RST;
            level         <= LEVEL_W'(1);
            serve         <= 1'b0;
            level_restart <= 1'b0;
            ball_lost_q   <= 1'b0;
            restart_d1    <= 1'b0;
            restart_d2    <= 1'b0;
        end else begin
            state         <= state_nxt;
            lives         <= lives_nxt;
            level         <= level_nxt;
            serve         <= serve_nxt;
            level_restart <= restart_nxt;
            ball_lost_q   <= ball_lost;
            restart_d1    <= level_restart;
            restart_d2    <= restart_d1;
        end
    end

    always_comb begin
        state_nxt   = state;
        lives_nxt   = lives;
        level_nxt   = level;
        serve_nxt   = 1'b0;
        restart_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = SERVE;
                    serve_nxt   = 1'b1;
                    restart_nxt = 1'b1;
                end
            end
            SERVE: begin
                if (!start) begin
                    state_nxt = IDLE;
                end else if (timer_done) begin
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (block_bottom) begin
                    state_nxt = GAME_OVER;
                end else if (lost_evt) begin
                    if (lives <= LIVES_W'(1)) begin
                        lives_nxt = '0;
                        state_nxt = GAME_OVER;
                    end else begin
                        lives_nxt = lives - 1'b1;
                        state_nxt = PAUSE_LOST;
                    end
                end else if ((blocks_alive == '0) && !clear_guard) begin
                    if (level >= LEVEL_MAX) begin
                        state_nxt = WIN;
                    end else begin
                        level_nxt = level + 1'b1;
                        state_nxt = PAUSE_CLEAR;
                    end
                end else if (!start) begin
                    state_nxt = IDLE;
                end
            end
            PAUSE_LOST: begin
                if (timer_done) begin
                    state_nxt = SERVE;
                    serve_nxt = 1'b1;
                end
            end
            PAUSE_CLEAR: begin
                if (timer_done) begin
                    state_nxt   = SERVE;
                    serve_nxt   = 1'b1;
                    restart_nxt = 1'b1;
                end
            end
            GAME_OVER, WIN: state_nxt = state;
            default:        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        run       = (state == PLAY);
        game_over = (state == GAME_OVER);
        game_won  = (state == WIN);
        state_dbg = state;
    end

endmodule
